// File: rtl/seq_pkg.sv
// Shared encodings for the datapath sequencer: FSM states, instruction fields and op codes.
package seq_pkg;

    localparam int unsigned INSTR_W = 24;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned CLS_W   = 2;
    localparam int unsigned RET_W   = 16;

    // Instruction field bit positions
    localparam int unsigned CLS_HI = 23;
    localparam int unsigned CLS_LO = 22;
    localparam int unsigned OP_HI  = 21;
    localparam int unsigned OP_LO  = 18;
    localparam int unsigned DA_HI  = 17;
    localparam int unsigned DA_LO  = 16;
    localparam int unsigned AA_HI  = 15;
    localparam int unsigned AA_LO  = 14;
    localparam int unsigned BA_HI  = 13;
    localparam int unsigned BA_LO  = 12;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPRD   = 3'd2,
        S_ALU    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Instruction classes
    localparam logic [CLS_W-1:0] CLS_ALU_REG = 2'b00;
    localparam logic [CLS_W-1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [CLS_W-1:0] CLS_MEM     = 2'b10;
    localparam logic [CLS_W-1:0] CLS_CTRL    = 2'b11;

    // Memory-class ops
    localparam logic [OP_W-1:0] OP_LD = 4'b0000;
    localparam logic [OP_W-1:0] OP_ST = 4'b0001;

    // Control-class ops
    localparam logic [OP_W-1:0] OP_JMP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_BZ   = 4'b0001;
    localparam logic [OP_W-1:0] OP_BN   = 4'b0010;
    localparam logic [OP_W-1:0] OP_HALT = 4'b0011;

    localparam logic [OP_W-1:0] FS_PASS = 4'b0000;

    // True for the two classes that write an ALU result back
    function automatic logic isAluClass(input logic [CLS_W-1:0] cls);
        return (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational control-word decode from FSM state and the latched instruction.
module seq_decode
    import seq_pkg::*;
(
    input  state_t              state,
    input  logic [INSTR_W-1:0]  ir,
    output logic                rw_c,
    output logic                mb_c,
    output logic                md_c,
    output logic [REG_W-1:0]    da_c,
    output logic [REG_W-1:0]    aa_c,
    output logic [REG_W-1:0]    ba_c,
    output logic [OP_W-1:0]     fs_c,
    output logic [DATA_W-1:0]   con_c,
    output logic                memRd_c,
    output logic                memWr_c,
    output logic                illegal_c
);

    logic [CLS_W-1:0] cls;
    logic [OP_W-1:0]  op;
    logic             isLd;
    logic             isSt;
    logic             unusedRsvd;

    assign cls        = ir[CLS_HI:CLS_LO];
    assign op         = ir[OP_HI:OP_LO];
    assign isLd       = (cls == CLS_MEM) && (op == OP_LD);
    assign isSt       = (cls == CLS_MEM) && (op == OP_ST);
    // Reserved instruction bits carry no meaning
    assign unusedRsvd = ^ir[11:8];

    // Register selects always follow IR; strobes only fire in their owning state
    always_comb begin
        rw_c      = 1'b0;
        md_c      = 1'b0;
        memRd_c   = 1'b0;
        memWr_c   = 1'b0;
        illegal_c = 1'b0;
        da_c      = ir[DA_HI:DA_LO];
        aa_c      = ir[AA_HI:AA_LO];
        ba_c      = ir[BA_HI:BA_LO];
        mb_c      = (cls == CLS_ALU_IMM);
        con_c     = (cls == CLS_ALU_IMM) ? ir[IMM_HI:IMM_LO] : DATA_W'(0);
        fs_c      = isAluClass(cls) ? op : FS_PASS;
        case (state)
            S_WB: begin
                rw_c = 1'b1;
                md_c = isLd;
            end
            S_MEM: begin
                memRd_c   = isLd;
                memWr_c   = isSt;
                illegal_c = (cls == CLS_MEM) && !isLd && !isSt;
            end
            S_BRANCH: begin
                illegal_c = (cls == CLS_CTRL) && (op > OP_HALT);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit: fetch/decode FSM, PC, IR, flags and retired counter.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_i,
    output logic [PC_W-1:0]     imem_addr_o,
    input  logic [INSTR_W-1:0]  imem_data_i,
    input  logic [DATA_W-1:0]   f_i,
    output logic                RW,
    output logic                MB,
    output logic                MD,
    output logic [REG_W-1:0]    DA,
    output logic [REG_W-1:0]    AA,
    output logic [REG_W-1:0]    BA,
    output logic [OP_W-1:0]     FS,
    output logic [DATA_W-1:0]   Con_out,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    output logic                halted_o,
    output logic                illegal_o,
    output logic [1:0]          flags_o,
    output logic [RET_W-1:0]    retired_o
);

    state_t             state;
    state_t             nextState;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               flagN;
    logic               flagZ;
    logic [RET_W-1:0]   retired;
    logic               retire;
    logic               branchTaken;
    logic [CLS_W-1:0]   irCls;
    logic [OP_W-1:0]    irOp;
    logic [CLS_W-1:0]   fetchCls;

    assign irCls    = ir[CLS_HI:CLS_LO];
    assign irOp     = ir[OP_HI:OP_LO];
    assign fetchCls = imem_data_i[CLS_HI:CLS_LO];

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, retirement and branch resolution
    always_comb begin
        nextState   = state;
        retire      = 1'b0;
        branchTaken = 1'b0;
        case (state)
            S_FETCH: begin
                if (run_i) begin
                    nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                // IR is still loading, so route on the ROM word directly
                nextState = (fetchCls == CLS_CTRL) ? S_BRANCH : S_OPRD;
            end
            S_OPRD: begin
                nextState = (irCls == CLS_MEM) ? S_MEM : S_ALU;
            end
            S_ALU: begin
                nextState = S_WB;
            end
            S_MEM: begin
                if (irOp == OP_LD) begin
                    nextState = S_WB;
                end else begin
                    nextState = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_WB: begin
                nextState = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                retire      = 1'b1;
                nextState   = (irOp == OP_HALT) ? S_HALT : S_FETCH;
                branchTaken = (irOp == OP_JMP)
                           || ((irOp == OP_BZ) && flagZ)
                           || ((irOp == OP_BN) && flagN);
            end
            S_HALT: begin
                nextState = S_HALT;
            end
            default: begin
                nextState = S_FETCH;
            end
        endcase
    end

    // PC and IR: latch the ROM word and advance in decode, redirect on a taken branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            ir <= INSTR_W'(0);
        end else if (state == S_DECODE) begin
            ir <= imem_data_i;
            pc <= pc + PC_W'(1);
        end else if (branchTaken) begin
            pc <= PC_W'(ir[IMM_HI:IMM_LO]);
        end
    end

    // Flags follow only ALU-class write-backs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flagN <= 1'b0;
            flagZ <= 1'b0;
        end else if ((state == S_WB) && isAluClass(irCls)) begin
            flagZ <= (f_i == DATA_W'(0));
            flagN <= f_i[DATA_W-1];
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= RET_W'(0);
        end else if (retire) begin
            retired <= retired + RET_W'(1);
        end
    end

    seq_decode u_decode (
        .state     (state),
        .ir        (ir),
        .rw_c      (RW),
        .mb_c      (MB),
        .md_c      (MD),
        .da_c      (DA),
        .aa_c      (AA),
        .ba_c      (BA),
        .fs_c      (FS),
        .con_c     (Con_out),
        .memRd_c   (mem_rd_o),
        .memWr_c   (mem_wr_o),
        .illegal_c (illegal_o)
    );

    assign imem_addr_o = pc;
    assign halted_o    = (state == S_HALT);
    assign flags_o     = {flagN, flagZ};
    assign retired_o   = retired;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Hardwired multi-cycle control unit that fetches 24-bit instructions from a synchronous instruction ROM and drives the 8-bit register-file/ALU datapath control word: RW, DA, AA, BA, MB, FS, MD, Con_out. It also drives data-memory strobes, keeps PC, zero/negative flags and a retired-instruction counter, and resolves jumps and conditional branches. It sits beside the datapath in the CPU top.

Parameters:
PC_W, 8, program counter and instruction-ROM address width.
RESET_PC, 0, PC value loaded at reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
run_i  in  1  enables a new fetch; sampled only in S_FETCH.
imem_addr_o  out  PC_W  instruction-ROM address; equals PC.
imem_data_i  in  24  ROM data; valid one cycle after the address.
f_i  in  8  datapath ALU result F.
RW, MB, MD  out  1  datapath register write, B-mux select and D-mux select.
DA, AA, BA  out  2  datapath destination, A and B register selects.
FS  out  4  datapath function select.
Con_out  out  8  immediate fed to the datapath Con_in.
mem_rd_o, mem_wr_o  out  1  data-memory strobes. Address is the datapath Address_out; write data is the datapath Data_out.
halted_o  out  1  high in S_HALT.
illegal_o  out  1  one-cycle pulse on an undefined opcode.
flags_o  out  2  {N,Z} from the last ALU-class write-back.
retired_o  out  16  count of retired instructions; wraps from 0xFFFF to 0.

Behaviour:
- Instruction format:
  - [23:22] class: 00 ALU-reg, 01 ALU-imm, 10 memory, 11 control.
  - [21:18] op, [17:16] DA, [15:14] AA, [13:12] BA, [11:8] reserved (ignored), [7:0] imm8.
- FSM states: S_FETCH, S_DECODE, S_OPRD, S_ALU, S_MEM, S_WB, S_BRANCH, S_HALT. 3-bit encoding.
- Transitions:
  - S_FETCH drives imem_addr_o=PC. Goes to S_DECODE only if run_i=1, otherwise stays.
  - S_DECODE: IR<=imem_data_i, PC<=PC+1 (wraps modulo 2^PC_W).
  - From S_DECODE: classes 00/01/10 go to S_OPRD; class 11 goes to S_BRANCH.
  - From S_OPRD: classes 00/01 go to S_ALU; class 10 goes to S_MEM.
  - S_ALU goes to S_WB.
  - S_MEM: LD goes to S_WB; ST goes to S_FETCH.
  - S_WB and S_BRANCH go to S_FETCH, except HALT, which goes to S_HALT.
  - S_HALT is left only by reset.
- Latency per instruction:
  - ALU and LD: 5 cycles (FETCH, DECODE, OPRD, ALU or MEM, WB).
  - ST: 4 cycles.
  - Control class: 3 cycles.
- Control word is combinational from state and IR:
  - DA/AA/BA come from IR fields in every state.
  - MB=1 only for class 01. Con_out = imm8 for class 01, otherwise 0.
  - FS = op for classes 00/01, otherwise 0000.
  - RW=1 only in S_WB.
  - MD=1 only in S_WB of LD.
  - mem_rd_o=1 only in S_MEM of LD; mem_wr_o=1 only in S_MEM of ST.
- Memory ops: 0000 LD, 0001 ST. Any other memory op is illegal and is treated as a 4-cycle NOP with no strobes.
- Control ops:
  - 0000 JMP: PC<=imm8.
  - 0001 BZ: PC<=imm8 if Z=1.
  - 0010 BN: PC<=imm8 if N=1.
  - 0011 HALT.
  - Any other op is illegal and acts as a NOP.
  - Targets are zero-extended or truncated to PC_W.
  - A branch reads the flag values current at entry to S_BRANCH.
- Flags: in S_WB of classes 00/01 only, Z<=(f_i==0) and N<=f_i[7]. LD and ST leave flags unchanged.
- illegal_o pulses in S_MEM (class 10) or S_BRANCH (class 11).
- retired_o increments at the edge leaving S_WB, S_MEM(ST), S_BRANCH and S_MEM(illegal). HALT and illegal instructions count.
- run_i falling mid-instruction: the instruction completes; the FSM then waits in S_FETCH.
- Reset values: state=S_FETCH, PC=RESET_PC, IR=0, flags=0, retired=0. All strobes and control outputs are 0; halted_o=0.
- Reset mid-instruction aborts immediately. RW and the mem strobes drop asynchronously with rst_n.

Decomposition:
- Package seq_pkg holds:
  - the state enum;
  - class codes;
  - memory and control op codes;
  - IR field bit positions;
  - the FS_PASS constant (0000).
- One sub-module, seq_decode: combinational mapping {state, IR} to control word, mem strobes and illegal. The FSM, PC, IR, flags and counter stay in datapath_sequencer.

Test Plan:
- Reset with run_i=0 -> PC=0, state S_FETCH held, RW=0, retired_o=0. Raise run_i -> S_DECODE next cycle and imem_addr_o=0.
- ALU-reg FS=0010 DA=3 AA=1 BA=2, with datapath R1=5 and R2=7 -> RW high exactly in cycle 5 with DA=3, MD=0; R3=12; flags_o=00; retired_o=1.
- ALU-imm FS=1100 imm=0x40 DA=0, then LD DA=1 AA=0 -> R0=0x40. mem_rd_o is one cycle with Address_out=0x40. Then RW=1 with MD=1.
- FS=0101 AA=BA=R1 gives 0, so Z=1. Then BZ imm=0x10 -> PC=0x10. Then BN 0x20 with N=0 -> PC=0x11.
- RESET_PC=0xFF with an ALU instruction there -> next imem_addr_o=0x00. Then HALT -> halted_o=1, RW stays 0, state held until rst_n.
- Memory op 0111 -> illegal_o one pulse, no strobes, retired+1. rst_n asserted during S_WB -> RW falls immediately and PC=RESET_PC.
